sa_read_arbiter: RTL

//  Per-slave read arbiter: the stage directly downstream of the per-master read dispatchers.

---
 rtl/sa_read_arbiter_pkg.sv | 20 ++
 rtl/sa_order_fifo.sv | 77 +++++++
 rtl/sa_read_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sa_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sa_read_arbiter_pkg
//   Shared interconnect definitions for the per-slave read arbiter:
//   default AXI field widths and a clog2 helper that never returns 0.
// -----------------------------------------------------------------------------
package sa_read_arbiter_pkg;

  localparam int DEF_TRANS_MST_ID_W    = 5;
  localparam int DEF_TRANS_BURST_W     = 2;
  localparam int DEF_TRANS_DATA_LEN_W  = 3;
  localparam int DEF_TRANS_DATA_SIZE_W = 3;
  localparam int DEF_TRANS_WR_RESP_W   = 2;

  // Index width for n items, with a floor of 1 so a single item still
  // gets a legal one-bit vector.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : sa_read_arbiter_pkg

// File: rtl/sa_order_fifo.sv
// -----------------------------------------------------------------------------
// sa_order_fifo
//   Synchronous FIFO recording which master owns each outstanding read burst,
//   in AR issue order.
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   WIDTH-bit master index
//   pop        in   drop the head entry (ignored when empty)
//   head       out  entry at the head (valid only when !empty)
//   empty      out  no entries stored
//   full       out  DEPTH entries stored (from the registered count)
// -----------------------------------------------------------------------------
module sa_order_fifo
  import sa_read_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop  & ~empty;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only read between a
  // push and its pop, so clearing them would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule : sa_order_fifo

// File: rtl/sa_read_arbiter.sv
// -----------------------------------------------------------------------------
// sa_read_arbiter
//   Per-slave read arbiter. Grants one master AR request per cycle in
//   round-robin order, registers it onto the slave AR port, records the
//   granted master in an order FIFO and steers the slave's in-order R bursts
//   back to that master.
// Ports
//   ACLK_i, ARESET_i          clock; synchronous active-high reset
//   m_AR*_i                   per-master AR payload/valid, master i at slice i
//   m_ARREADY_o               one-hot grant (combinational from m_ARVALID_i)
//   m_RID/RDATA/RRESP/RLAST_o slave R payload broadcast to every master
//   m_RVALID_o                R valid, only toward the FIFO-head master
//   m_RREADY_i                per-master R ready
//   s_AR*_o, s_ARVALID_o      registered AR toward the slave
//   s_ARREADY_i               slave AR ready
//   s_R*_i, s_RVALID_i        slave R channel
//   s_RREADY_o                R ready toward the slave (head master's ready)
// -----------------------------------------------------------------------------
module sa_read_arbiter
  import sa_read_arbiter_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = DEF_TRANS_MST_ID_W,
  parameter int TRANS_BURST_W     = DEF_TRANS_BURST_W,
  parameter int TRANS_DATA_LEN_W  = DEF_TRANS_DATA_LEN_W,
  parameter int TRANS_DATA_SIZE_W = DEF_TRANS_DATA_SIZE_W,
  parameter int TRANS_WR_RESP_W   = DEF_TRANS_WR_RESP_W
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  // AR from the per-master dispatchers
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     m_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         m_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      m_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   m_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  m_ARSIZE_i,
  input  logic [MST_AMT-1:0]                    m_ARVALID_i,
  output logic [MST_AMT-1:0]                    m_ARREADY_o,
  // R back to the masters
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]     m_RID_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]         m_RDATA_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]    m_RRESP_o,
  output logic [MST_AMT-1:0]                    m_RLAST_o,
  output logic [MST_AMT-1:0]                    m_RVALID_o,
  input  logic [MST_AMT-1:0]                    m_RREADY_i,
  // AR to the slave
  output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  // R from the slave
  input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
  input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
  input  logic [TRANS_WR_RESP_W-1:0]            s_RRESP_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  output logic                                  s_RREADY_o
);

  localparam int MST_ID_W = clog2_min1(MST_AMT);

  logic [MST_ID_W-1:0] rr_ptr;
  logic [MST_ID_W-1:0] winner;
  logic                found;
  logic                grant_en;
  logic                grant;
  logic [MST_ID_W-1:0] fifo_head;
  logic                fifo_empty;
  logic                fifo_full;
  logic                fifo_pop;

  // ---------------------------------------------------------------------------
  // Round-robin winner: first valid request at or after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it holding its old value (no latch).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      if (!found && m_ARVALID_i[(int'(rr_ptr) + i) % MST_AMT]) begin
        found  = 1'b1;
        winner = MST_ID_W'((int'(rr_ptr) + i) % MST_AMT);
      end
    end
  end

  // The output slot is free when empty or draining this cycle. Fullness is
  // taken from the registered count: an R-side pop in the same cycle does
  // not open a slot, which keeps R ready out of the AR ready path.
  assign grant_en    = (~s_ARVALID_o | s_ARREADY_i) & ~fifo_full & ~ARESET_i;
  assign grant       = grant_en & found;
  assign m_ARREADY_o = grant ? (MST_AMT'(1) << winner) : '0;

  // ---------------------------------------------------------------------------
  // AR register stage and round-robin pointer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      s_ARID_o    <= '0;
      s_ARADDR_o  <= '0;
      s_ARBURST_o <= '0;
      s_ARLEN_o   <= '0;
      s_ARSIZE_o  <= '0;
      s_ARVALID_o <= 1'b0;
      rr_ptr      <= '0;
    end else if (grant) begin
      s_ARID_o    <= m_ARID_i[int'(winner)*TRANS_MST_ID_W +: TRANS_MST_ID_W];
      s_ARADDR_o  <= m_ARADDR_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      s_ARBURST_o <= m_ARBURST_i[int'(winner)*TRANS_BURST_W +: TRANS_BURST_W];
      s_ARLEN_o   <= m_ARLEN_i[int'(winner)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
      s_ARSIZE_o  <= m_ARSIZE_i[int'(winner)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      s_ARVALID_o <= 1'b1;
      rr_ptr      <= (winner == MST_ID_W'(MST_AMT - 1)) ? '0 : winner + MST_ID_W'(1);
    end else if (s_ARREADY_i) begin
      // Payload is left as-is; only valid drops after the handshake.
      s_ARVALID_o <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Order FIFO: granted master indices in issue order.
  // ---------------------------------------------------------------------------
  assign fifo_pop = s_RVALID_i & s_RREADY_o & s_RLAST_i;

  sa_order_fifo #(
    .WIDTH (MST_ID_W),
    .DEPTH (OUTSTANDING_AMT)
  ) u_order_fifo (
    .clk       (ACLK_i),
    .rst       (ARESET_i),
    .push      (grant),
    .push_data (winner),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // ---------------------------------------------------------------------------
  // R demux: payload broadcast, valid/ready steered by the FIFO head. With the
  // FIFO empty the slave is refused, so stale beats after a reset are held off.
  // ---------------------------------------------------------------------------
  assign m_RID_o    = {MST_AMT{s_RID_i}};
  assign m_RDATA_o  = {MST_AMT{s_RDATA_i}};
  assign m_RRESP_o  = {MST_AMT{s_RRESP_i}};
  assign m_RLAST_o  = {MST_AMT{s_RLAST_i}};
  assign m_RVALID_o = (s_RVALID_i & ~fifo_empty) ? (MST_AMT'(1) << fifo_head) : '0;
  assign s_RREADY_o = ~fifo_empty & m_RREADY_i[fifo_head];

endmodule : sa_read_arbiter
